// File: rtl/seg_display_if.sv
// Display bus for seg_display: value to show in, segment and anode drives out.
interface seg_display_if;
  logic [7:0] gdc;
  logic [6:0] sal;
  logic [3:0] an;

  modport master (output gdc, input sal, input an);
  modport slave  (input gdc, output sal, output an);
endinterface

// File: rtl/seg_display.sv
// 4-digit common-anode multiplexed 7-segment driver showing an 8-bit value in decimal
// with leading-zero blanking; segments and anodes are registered together.
module seg_display #(
  parameter int N = 18
) (
  input  logic          clk,
  input  logic          reset,
  seg_display_if.slave  bus
);

  typedef enum logic [1:0] {
    SLOT_U   = 2'd0,
    SLOT_T   = 2'd1,
    SLOT_H   = 2'd2,
    SLOT_OFF = 2'd3
  } slot_e;

  localparam logic [6:0] BLANK = 7'b1111111;

  logic [N-1:0] cnt;
  slot_e        slot;
  logic [11:0]  bcd;
  logic [6:0]   sal_d;
  logic [3:0]   an_d;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = BLANK;
    endcase
  endfunction

  assign slot = slot_e'(cnt[N-1:N-2]);

  // Double-dabble: bcd = {hundreds, tens, units}.
  always_comb begin
    bcd = '0;
    for (int i = 7; i >= 0; i--) begin
      if (bcd[3:0]  >= 4'd5) bcd[3:0]  = bcd[3:0]  + 4'd3;
      if (bcd[7:4]  >= 4'd5) bcd[7:4]  = bcd[7:4]  + 4'd3;
      if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
      bcd = {bcd[10:0], bus.gdc[i]};
    end
  end

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    an_d  = 4'b1111;
    sal_d = BLANK;
    case (slot)
      SLOT_U: begin
        an_d  = 4'b1110;
        sal_d = seg_code(bcd[3:0]);
      end
      SLOT_T: begin
        an_d = 4'b1101;
        if (bus.gdc >= 8'd10) sal_d = seg_code(bcd[7:4]);
      end
      SLOT_H: begin
        an_d = 4'b1011;
        if (bus.gdc >= 8'd100) sal_d = seg_code(bcd[11:8]);
      end
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments keep all registers sampling the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      bus.sal <= BLANK;
      bus.an  <= 4'b1111;
    end else begin
      cnt     <= cnt + {{(N-1){1'b0}}, 1'b1};
      bus.sal <= sal_d;
      bus.an  <= an_d;
    end
  end

endmodule

// File: tb/tb_seg_display.sv
// Scoreboard bench for seg_display at N=4: expected {an,sal} pushed per clock, popped after the edge.
module tb_seg_display;

  localparam int N = 4;
  localparam int SLOT_LEN = 2 ** (N - 2);

  logic clk = 1'b0;
  logic reset = 1'b0;

  seg_display_if bus ();

  seg_display #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [10:0] sb [$];
  int m_cnt  = 0;
  int passed = 0;
  int total  = 0;

  function automatic logic [10:0] model(input int c, input int g);
    int slot;
    slot = (c / SLOT_LEN) % 4;
    case (slot)
      0:       return {4'b1110, seg_tab[g % 10]};
      1:       return {4'b1101, (g >= 10)  ? seg_tab[(g / 10) % 10] : 7'b1111111};
      2:       return {4'b1011, (g >= 100) ? seg_tab[g / 100]       : 7'b1111111};
      default: return {4'b1111, 7'b1111111};
    endcase
  endfunction

  // Push the expectation for the coming edge, clock once, sample 1 ns after the edge.
  task automatic run_cycle(output logic [3:0] a, output logic [6:0] s);
    sb.push_back(model(m_cnt, int'(bus.gdc)));
    m_cnt = (m_cnt + 1) % (2 ** N);
    @(posedge clk);
    #1;
    a = bus.an;
    s = bus.sal;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    m_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic scan(input logic [7:0] g, input int cycles, input string name);
    logic [3:0]  a;
    logic [6:0]  s;
    logic [10:0] e;
    bus.gdc = g;
    for (int i = 0; i < cycles; i++) begin
      run_cycle(a, s);
      e = sb.pop_front();
      total++;
      if ({a, s} !== e)
        $display("FAIL %s gdc=%0d cyc %0d: an=%b sal=%b, expected an=%b sal=%b",
                 name, g, i, a, s, e[10:7], e[6:0]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    bus.gdc = 8'hF0;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.an, bus.sal} !== 11'b1111_1111111)
      $display("FAIL reset_async: an=%b sal=%b, expected an=1111 sal=1111111", bus.an, bus.sal);
    else passed++;
    m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({bus.an, bus.sal} !== 11'b1111_1111111)
        $display("FAIL reset_hold %0d: an=%b sal=%b, expected an=1111 sal=1111111", i, bus.an, bus.sal);
      else passed++;
    end
    reset = 1'b0;
  endtask

  task automatic test_scan_240();
    logic [10:0] fixed [4] = '{11'b1110_1000000, 11'b1101_0011001, 11'b1011_0100100, 11'b1111_1111111};
    logic [3:0]  a;
    logic [6:0]  s;
    logic [10:0] e;
    bus.gdc = 8'd240;
    for (int i = 0; i < 4 * SLOT_LEN * 2; i++) begin
      run_cycle(a, s);
      e = sb.pop_front();
      total++;
      if ({a, s} !== e)
        $display("FAIL scan_240 cyc %0d: an=%b sal=%b, expected an=%b sal=%b", i, a, s, e[10:7], e[6:0]);
      else passed++;
      if (i % SLOT_LEN == 0) begin
        total++;
        if ({a, s} !== fixed[(i / SLOT_LEN) % 4])
          $display("FAIL scan_240_fixed cyc %0d: an=%b sal=%b, expected %b", i, a, s, fixed[(i / SLOT_LEN) % 4]);
        else passed++;
      end
    end
  endtask

  task automatic test_blanking();
    apply_reset();
    scan(8'd7,   4 * SLOT_LEN, "blank_7");
    scan(8'd100, 4 * SLOT_LEN, "blank_100");
    scan(8'd10,  4 * SLOT_LEN, "blank_10");
    scan(8'd99,  4 * SLOT_LEN, "blank_99");
  endtask

  task automatic test_extremes();
    scan(8'd0,   4 * SLOT_LEN, "extreme_0");
    scan(8'd255, 4 * SLOT_LEN, "extreme_255");
    scan(8'd9,   4 * SLOT_LEN, "extreme_9");
    scan(8'd200, 4 * SLOT_LEN, "extreme_200");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++)
      scan(8'($urandom_range(0, 255)), 4 * SLOT_LEN + 1, "random");
  endtask

  task automatic test_gdc_change();
    logic [3:0]  a;
    logic [6:0]  s;
    logic [10:0] e;
    apply_reset();
    bus.gdc = 8'd240;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.gdc = 8'd255;
      run_cycle(a, s);
      e = sb.pop_front();
      total++;
      if ({a, s} !== e)
        $display("FAIL gdc_change cyc %0d: an=%b sal=%b, expected an=%b sal=%b", i, a, s, e[10:7], e[6:0]);
      else passed++;
      total++;
      if (s !== ((i == 2) ? 7'b0010010 : 7'b1000000))
        $display("FAIL gdc_change_sal cyc %0d: sal=%b, expected %b", i, s,
                 (i == 2) ? 7'b0010010 : 7'b1000000);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [3:0] a;
    logic [6:0] s;
    apply_reset();
    scan(8'd240, 2 * SLOT_LEN + 1, "pre_reset");
    total++;
    if (bus.an !== 4'b1011)
      $display("FAIL mid_reset_slot2: an=%b, expected 1011", bus.an);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.an, bus.sal} !== 11'b1111_1111111)
      $display("FAIL mid_reset_dark: an=%b sal=%b, expected an=1111 sal=1111111", bus.an, bus.sal);
    else passed++;
    m_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_cycle(a, s);
    void'(sb.pop_front());
    total++;
    if ({a, s} !== 11'b1110_1000000)
      $display("FAIL mid_reset_restart: an=%b sal=%b, expected an=1110 sal=1000000", a, s);
    else passed++;
    scan(8'd240, 4 * SLOT_LEN, "post_reset");
  endtask

  initial begin
    bus.gdc = 8'hF0;
    test_reset();
    test_scan_240();
    test_blanking();
    test_extremes();
    test_random();
    test_gdc_change();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
